// File: rtl/layered_objects_mux_pkg.sv
// objects_mux_pkg: types and helpers shared by the layered objects mux and by
// the overlay units (digits, debug) that use the same RGB332 colour format.
//   rgb332_t             - 8-bit colour, {R[2:0], G[2:0], B[1:0]}
//   rgb24_t              - expanded 8/8/8 colour
//   TRANSPARENT_DEFAULT  - RGB332 value meaning "layer not drawn"
//   expand_rgb332()      - RGB332 -> rgb24_t, replicating the LSB of each field
package objects_mux_pkg;

    typedef logic [7:0] rgb332_t;

    typedef struct packed {
        logic [7:0] red;
        logic [7:0] green;
        logic [7:0] blue;
    } rgb24_t;

    localparam rgb332_t TRANSPARENT_DEFAULT = 8'hFF;

    // Replicating the field LSB maps the all-ones code to 8'hFF and zero to 8'h00.
    function automatic rgb24_t expand_rgb332(input rgb332_t c);
        rgb24_t o;
        o.red   = {c[7:5], {5{c[5]}}};
        o.green = {c[4:2], {5{c[2]}}};
        o.blue  = {c[1:0], {6{c[0]}}};
        return o;
    endfunction

endpackage

// File: rtl/layered_objects_mux_if.sv
// layered_objects_mux_if: pixel-path bundle between the drawing units and the
// layered objects mux.
//   layerRequest/layerRGB   per-layer request and RGB332 colour
//   backGroundRGB           background RGB332 colour
//   layerEnableNext         enable mask loaded on startOfFrame
//   startOfFrame            one-cycle pulse at the first pixel of a frame
//   redOut/greenOut/blueOut expanded colour (2-clock latency)
//   winLayer                winning layer index, NUM_LAYERS = background
//   collisionFlags/Any      layer-0 collisions of the previous frame
// Modports: master = drawing side (drives inputs), slave = the mux.
interface layered_objects_mux_if #(
    parameter int NUM_LAYERS = 6
);
    import objects_mux_pkg::*;

    localparam int WIN_W = $clog2(NUM_LAYERS + 1);

    logic    [NUM_LAYERS-1:0]       layerRequest;
    rgb332_t [NUM_LAYERS-1:0]       layerRGB;
    rgb332_t                        backGroundRGB;
    logic    [NUM_LAYERS-1:0]       layerEnableNext;
    logic                           startOfFrame;
    logic    [7:0]                  redOut;
    logic    [7:0]                  greenOut;
    logic    [7:0]                  blueOut;
    logic    [WIN_W-1:0]            winLayer;
    logic    [NUM_LAYERS-1:0]       collisionFlags;
    logic                           collisionAny;

    modport master (
        output layerRequest, layerRGB, backGroundRGB, layerEnableNext, startOfFrame,
        input  redOut, greenOut, blueOut, winLayer, collisionFlags, collisionAny
    );

    modport slave (
        input  layerRequest, layerRGB, backGroundRGB, layerEnableNext, startOfFrame,
        output redOut, greenOut, blueOut, winLayer, collisionFlags, collisionAny
    );

endinterface

// File: rtl/layered_objects_mux_collision_tracker.sv
// collision_tracker: accumulates overlaps between layer 0 and every other
// layer during a frame and snapshots them on startOfFrame.
//   clk, resetN     pixel clock, asynchronous active-low reset
//   eff             effective (enabled, opaque, requesting) layer vector
//   startOfFrame    frame boundary pulse
//   collisionFlags  bit k = layer 0 overlapped layer k last frame (bit 0 = 0)
//   collisionAny    OR of collisionFlags
module collision_tracker #(
    parameter int NUM_LAYERS = 6
) (
    input  logic                  clk,
    input  logic                  resetN,
    input  logic [NUM_LAYERS-1:0] eff,
    input  logic                  startOfFrame,
    output logic [NUM_LAYERS-1:0] collisionFlags,
    output logic                  collisionAny
);

    logic [NUM_LAYERS-1:0] hit;
    logic [NUM_LAYERS-1:0] acc_d, acc_q;
    logic [NUM_LAYERS-1:0] flags_d, flags_q;

    always_comb begin
        hit = '0;
        for (int unsigned k = 1; k < NUM_LAYERS; k++) begin
            hit[k] = eff[0] & eff[k];
        end
    end

    // A hit in the pulse cycle belongs to the frame being closed.
    always_comb begin
        acc_d   = acc_q | hit;
        flags_d = flags_q;
        if (startOfFrame) begin
            flags_d = acc_q | hit;
            acc_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            acc_q   <= '0;
            flags_q <= '0;
        end else begin
            acc_q   <= acc_d;
            flags_q <= flags_d;
        end
    end

    assign collisionFlags = flags_q;
    assign collisionAny   = |flags_q;

endmodule

// File: rtl/layered_objects_mux.sv
// layered_objects_mux: N-layer priority compositor for the VGA pixel path.
// Picks the lowest-index enabled, requesting, non-transparent layer (else the
// background), expands RGB332 to 24-bit colour with 2 clocks of latency, and
// optionally reports layer-0 collisions per frame.
//   clk, resetN  pixel clock, asynchronous active-low reset
//   bus          layered_objects_mux_if.slave (see interface header)
// Build option: define COLLISION_DETECT_EN to build the collision tracker;
// otherwise collisionFlags/collisionAny are tied to 0.
module layered_objects_mux
    import objects_mux_pkg::*;
#(
    parameter int      NUM_LAYERS  = 6,
    parameter rgb332_t TRANSPARENT = TRANSPARENT_DEFAULT
) (
    input  logic                 clk,
    input  logic                 resetN,
    layered_objects_mux_if.slave bus
);

    localparam int               WIN_W  = $clog2(NUM_LAYERS + 1);
    localparam logic [WIN_W-1:0] BG_WIN = WIN_W'(NUM_LAYERS);

    logic [NUM_LAYERS-1:0] en_mask_d, en_mask_q;
    logic [NUM_LAYERS-1:0] eff;
    rgb332_t               sel_rgb_d, sel_rgb_q;
    logic [WIN_W-1:0]      sel_win_d, sel_win_q;
    rgb24_t                pix_d, pix_q;
    logic [WIN_W-1:0]      win_d, win_q;
    logic                  found;

    // Mask only changes at a frame boundary, effective the next cycle.
    always_comb begin
        en_mask_d = en_mask_q;
        if (bus.startOfFrame) begin
            en_mask_d = bus.layerEnableNext;
        end
    end

    always_comb begin
        eff = '0;
        for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
            eff[i] = bus.layerRequest[i] & en_mask_q[i] & (bus.layerRGB[i] != TRANSPARENT);
        end
    end

    always_comb begin
        sel_rgb_d = bus.backGroundRGB;
        sel_win_d = BG_WIN;
        found     = 1'b0;
        for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
            if (eff[i] && !found) begin
                sel_rgb_d = bus.layerRGB[i];
                sel_win_d = WIN_W'(i);
                found     = 1'b1;
            end
        end
    end

    always_comb begin
        pix_d = expand_rgb332(sel_rgb_q);
        win_d = sel_win_q;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            en_mask_q <= '1;
            sel_rgb_q <= '0;
            sel_win_q <= BG_WIN;
            pix_q     <= '0;
            win_q     <= BG_WIN;
        end else begin
            en_mask_q <= en_mask_d;
            sel_rgb_q <= sel_rgb_d;
            sel_win_q <= sel_win_d;
            pix_q     <= pix_d;
            win_q     <= win_d;
        end
    end

    assign bus.redOut   = pix_q.red;
    assign bus.greenOut = pix_q.green;
    assign bus.blueOut  = pix_q.blue;
    assign bus.winLayer = win_q;

`ifdef COLLISION_DETECT_EN
    collision_tracker #(
        .NUM_LAYERS(NUM_LAYERS)
    ) u_collision (
        .clk           (clk),
        .resetN        (resetN),
        .eff           (eff),
        .startOfFrame  (bus.startOfFrame),
        .collisionFlags(bus.collisionFlags),
        .collisionAny  (bus.collisionAny)
    );
`else
    assign bus.collisionFlags = '0;
    assign bus.collisionAny   = 1'b0;
`endif

endmodule

// File: doc/layered_objects_mux.md
# layered_objects_mux

Parametrised N-layer priority compositor for the VGA pixel path. It sits between the per-object drawing units (digits, player, birds, shots, trees, ground, and any layers added later) and the VGA output stage. Each pixel, it selects the highest-priority opaque, enabled layer, or the background when no layer qualifies, and expands RGB332 to 24-bit colour. It also reports per-frame collisions between layer 0 and every other layer.

## Interface
Parameters:
- NUM_LAYERS, 6, number of object layers; index 0 = highest priority; legal range 2..16
- TRANSPARENT, 8'hFF, RGB332 value treated as "not drawn" even when the layer's request is high

Ports:
- clk  in  1  pixel clock
- resetN  in  1  asynchronous, active-low reset
- layerRequest  in  NUM_LAYERS  per-layer drawing request
- layerRGB  in  NUM_LAYERS x 8  per-layer RGB332 colour
- backGroundRGB  in  8  background RGB332 colour
- layerEnableNext  in  NUM_LAYERS  requested enable mask; loaded on startOfFrame
- startOfFrame  in  1  one-cycle pulse at the first pixel of each frame
- redOut / greenOut / blueOut  out  8 each  expanded colour
- winLayer  out  $clog2(NUM_LAYERS+1)  index of the winning layer; NUM_LAYERS = background
- collisionFlags  out  NUM_LAYERS  bit k = layer 0 overlapped layer k during the previous frame; bit 0 always 0
- collisionAny  out  1  OR of collisionFlags

## Operation
- Enable mask: register enMask. Reset value is all ones. It loads layerEnableNext only in a cycle where startOfFrame=1, so a frame never changes mask part-way through. The new mask applies from the cycle after the pulse.
- Effective request: eff[i] = layerRequest[i] & enMask[i] & (layerRGB[i] != TRANSPARENT).
- Selection: the lowest i with eff[i]=1 wins. If no eff bit is set, the background wins. backGroundRGB is never tested against TRANSPARENT.
- Colour expansion of c[7:0]:
  - red = {c[7:5], 5 copies of c[5]}
  - green = {c[4:2], 5 copies of c[2]}
  - blue = {c[1:0], 6 copies of c[0]}
- Collision accumulator acc[NUM_LAYERS-1:1] (enabled by the macro):
  - acc[k] sets when eff[0] & eff[k] in the same cycle, and stays set until the next frame boundary.
  - On startOfFrame, collisionFlags <= acc | hit_this_cycle, where hit_this_cycle is the set-term computed in that same cycle. acc then restarts from zero.
  - A hit in the startOfFrame cycle therefore counts toward the frame just closing, not the new one.
  - collisionFlags is stable for one whole frame.
- Disabled or transparent layers never cause collisions.

## Timing
- Stage 1 (registered): selected RGB332 and winLayer.
- Stage 2 (registered): expanded red/green/blue; winLayer delayed to align with the colour.
- Pixel latency is 2 clocks, input to red/green/blue and winLayer. The VGA sync delay compensates for exactly 2.
- collisionFlags and collisionAny update 1 clock after the startOfFrame cycle.
- Reset values:
  - red/green/blue = 0
  - winLayer = NUM_LAYERS
  - collisionFlags = 0, collisionAny = 0
  - pipeline registers = 0
  - acc = 0
  - enMask = all ones
- Reset asserted mid-frame clears everything immediately. The first flags after release reflect only hits between release and the next startOfFrame.
- startOfFrame on consecutive cycles: each pulse snapshots and clears; behaviour is legal and deterministic.

## Configuration
- COLLISION_DETECT_EN defined: the accumulator and snapshot logic is built as described above.
- COLLISION_DETECT_EN undefined: no collision logic is built; collisionFlags and collisionAny are tied to 0. The pixel path, mask and latency are unchanged.

## Structure
- Shared package objects_mux_pkg:
  - RGB332 typedef
  - TRANSPARENT_DEFAULT constant
  - function expanding RGB332 to 24-bit colour (reused by the digits and debug overlays)
- Sub-module collision_tracker, instantiated under COLLISION_DETECT_EN:
  - inputs: eff vector, startOfFrame, clk, resetN
  - outputs: collisionFlags, collisionAny

## Test plan
- Reset, then no requests, backGroundRGB=8'h1C -> after 2 clocks: red=0x00, green=0xFF, blue=0x00, winLayer=6.
- layerRequest=6'b000110 with layerRGB[1]=8'hE0 and layerRGB[2]=8'h03 -> layer 1 wins: red=0xFF, green=0x00, blue=0x00, winLayer=1, exactly 2 clocks later.
- layerRequest[0]=1 with layerRGB[0]=8'hFF and layer 3 requesting 8'h1C -> layer 0 is transparent; layer 3 wins; green=0xFF; no collision recorded.
- layerEnableNext=6'b111101 applied mid-frame while layer 1 requests -> layer 1 still wins until startOfFrame; from the following cycle it loses to the next enabled layer or background.
- Frame with one pixel where layers 0 and 4 are both opaque, then startOfFrame -> next clock: collisionFlags=6'b010000, collisionAny=1. The following frame has no overlap -> flags clear after its startOfFrame.
- Overlap of layers 0 and 2 in the startOfFrame cycle itself -> flag bit 2 set in the snapshot taken at that pulse. With COLLISION_DETECT_EN undefined -> flags stay 0.
